// File: rtl/gbe_ctrl_pkg.sv
// Shared types for the GbE/loopback write steering and its round-robin readout controller.
package gbe_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PASS_GBE = 3'd1,
    PASS_LB  = 3'd2,
    DROP     = 3'd3,
    RESYNC   = 3'd4
  } state_t;

  localparam logic DEST_GBE = 1'b0;
  localparam logic DEST_LB  = 1'b1;

endpackage

// File: rtl/gbe_write_ctrl_if.sv
// Word stream in, FIFO-pair write port out, for gbe_write_ctrl.
interface gbe_write_ctrl_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTR_W  = 16
);
  logic              din_valid;
  logic [DATA_W-1:0] din;
  logic              din_eof;
  logic              gbe_afull;
  logic              lb_afull;
  logic [DATA_W-1:0] dout;
  logic              gbe_we;
  logic              lb_we;
  logic              frame_err;
  logic [CTR_W-1:0]  drop_ctr;
  logic [CTR_W-1:0]  pkt_ctr;

  modport master (
    output din_valid, din, din_eof, gbe_afull, lb_afull,
    input  dout, gbe_we, lb_we, frame_err, drop_ctr, pkt_ctr
  );

  modport slave (
    input  din_valid, din, din_eof, gbe_afull, lb_afull,
    output dout, gbe_we, lb_we, frame_err, drop_ctr, pkt_ctr
  );
endinterface

// File: rtl/gbe_sat_ctr.sv
// Saturating up-counter: increments on ce && inc, sticks at all-ones.
module gbe_sat_ctr #(
  parameter int unsigned CTR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             inc,
  output logic [CTR_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (ce && inc && (count != '1)) begin
      count <= count + CTR_W'(1);
    end
  end

endmodule

// File: rtl/gbe_write_ctrl.sv
// Steers whole fixed-length packets into the GbE or loopback FIFO, dropping packets that do not fit.
// Define GBE_WRITE_CTRL_STATS_EN to build the saturating drop/packet counters.
module gbe_write_ctrl
  import gbe_ctrl_pkg::*;
#(
  parameter int unsigned WORDS_PER_PACKET      = 7,
  parameter int unsigned WORDS_PER_PACKET_BITS = 3,
  parameter int unsigned DATA_W                = 64,
  parameter int unsigned DEST_BIT              = 0,
  parameter int unsigned CTR_W                 = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  gbe_write_ctrl_if.slave  bus
);

  localparam int unsigned WCW = WORDS_PER_PACKET_BITS;
  localparam logic [WCW-1:0] LAST_IDX = WCW'(WORDS_PER_PACKET - 1);

  state_t            state;
  logic [WCW-1:0]    word_ctr;
  logic [DATA_W-1:0] dout_q;
  logic              gbe_we_q;
  logic              lb_we_q;
  logic              frame_err_q;

  logic accept_c;
  logic last_c;
  logic hdr_dest_c;
  logic hdr_full_c;

  always_comb begin
    accept_c   = ce && bus.din_valid;
    last_c     = (word_ctr == LAST_IDX);
    hdr_dest_c = bus.din[DEST_BIT];
    hdr_full_c = (hdr_dest_c == DEST_LB) ? bus.lb_afull : bus.gbe_afull;
  end

  // Packet FSM; strobes default low so they only pulse on accepted words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      word_ctr    <= '0;
      dout_q      <= '0;
      gbe_we_q    <= 1'b0;
      lb_we_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      gbe_we_q    <= 1'b0;
      lb_we_q     <= 1'b0;
      frame_err_q <= 1'b0;
      if (accept_c) begin
        dout_q <= bus.din;
        unique case (state)
          IDLE: begin
            if (!hdr_full_c) begin
              gbe_we_q <= (hdr_dest_c == DEST_GBE);
              lb_we_q  <= (hdr_dest_c == DEST_LB);
            end
            if (bus.din_eof) begin
              frame_err_q <= 1'b1;
              word_ctr    <= '0;
            end else begin
              word_ctr <= WCW'(1);
              if (hdr_full_c)                 state <= DROP;
              else if (hdr_dest_c == DEST_LB) state <= PASS_LB;
              else                            state <= PASS_GBE;
            end
          end
          PASS_GBE, PASS_LB, DROP: begin
            gbe_we_q <= (state == PASS_GBE);
            lb_we_q  <= (state == PASS_LB);
            if (last_c) begin
              word_ctr    <= '0;
              frame_err_q <= !bus.din_eof;
              state       <= bus.din_eof ? IDLE : RESYNC;
            end else if (bus.din_eof) begin
              word_ctr    <= '0;
              frame_err_q <= 1'b1;
              state       <= IDLE;
            end else begin
              word_ctr <= word_ctr + WCW'(1);
            end
          end
          RESYNC: begin
            if (bus.din_eof) begin
              word_ctr <= '0;
              state    <= IDLE;
            end else begin
              word_ctr <= last_c ? '0 : word_ctr + WCW'(1);
            end
          end
          default: begin
            word_ctr <= '0;
            state    <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.dout      = dout_q;
  assign bus.gbe_we    = gbe_we_q;
  assign bus.lb_we     = lb_we_q;
  assign bus.frame_err = frame_err_q;

`ifdef GBE_WRITE_CTRL_STATS_EN
  logic pkt_inc_c;
  logic drop_inc_c;

  // A packet counts only when its final word carries eof exactly on time.
  always_comb begin
    pkt_inc_c  = accept_c && last_c && bus.din_eof &&
                 ((state == PASS_GBE) || (state == PASS_LB));
    drop_inc_c = accept_c && last_c && bus.din_eof && (state == DROP);
  end

  gbe_sat_ctr #(.CTR_W(CTR_W)) u_pkt_ctr (
    .clk   (clk),
    .rst   (rst),
    .ce    (ce),
    .inc   (pkt_inc_c),
    .count (bus.pkt_ctr)
  );

  gbe_sat_ctr #(.CTR_W(CTR_W)) u_drop_ctr (
    .clk   (clk),
    .rst   (rst),
    .ce    (ce),
    .inc   (drop_inc_c),
    .count (bus.drop_ctr)
  );
`else
  assign bus.pkt_ctr  = '0;
  assign bus.drop_ctr = '0;
`endif

endmodule

// File: tb/tb_gbe_write_ctrl.sv
// Bench for gbe_write_ctrl: packet table plus scoreboard of expected write strobes.
module tb_gbe_write_ctrl;
  import gbe_ctrl_pkg::*;

  localparam int unsigned WPP    = 7;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned CTR_W  = 16;
`ifdef GBE_WRITE_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic ce;
  always #5 clk = ~clk;

  gbe_write_ctrl_if #(.DATA_W(DATA_W), .CTR_W(CTR_W)) bus ();

  gbe_write_ctrl #(
    .WORDS_PER_PACKET      (WPP),
    .WORDS_PER_PACKET_BITS (3),
    .DATA_W                (DATA_W),
    .DEST_BIT              (0),
    .CTR_W                 (CTR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .bus (bus)
  );

  typedef struct {
    logic              gbe_we;
    logic              lb_we;
    logic              ferr;
    logic [DATA_W-1:0] data;
  } exp_t;

  typedef struct {
    string name;
    logic  dest;
    int    nwords;
    logic  gbe_af;
    logic  lb_af;
    int    raise_at;
    bit    gap;
    int    exp_writes;
    int    ferr_at;
    int    pkt_inc;
    int    drop_inc;
  } pkt_t;

  exp_t sb[$];
  pkt_t pkts[$];
  int   checks   = 0;
  int   failures = 0;
  int   exp_pkt  = 0;
  int   exp_drop = 0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_ctrs(input string name);
    chk({name, "_pkt_ctr"},  DATA_W'(bus.pkt_ctr),  STATS ? DATA_W'(exp_pkt)  : '0);
    chk({name, "_drop_ctr"}, DATA_W'(bus.drop_ctr), STATS ? DATA_W'(exp_drop) : '0);
  endtask

  // Drive one cycle at posedge+1, then compare the registered response one clock later.
  task automatic drive_word(input string name, input logic v, input logic c,
                            input logic [DATA_W-1:0] d, input logic eof, input exp_t e);
    exp_t got;
    ce            = c;
    bus.din_valid = v;
    bus.din       = d;
    bus.din_eof   = eof;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard_empty", name);
    end else begin
      got = sb.pop_front();
      chk({name, "_gbe_we"}, DATA_W'(bus.gbe_we), DATA_W'(got.gbe_we));
      chk({name, "_lb_we"},  DATA_W'(bus.lb_we),  DATA_W'(got.lb_we));
      chk({name, "_ferr"},   DATA_W'(bus.frame_err), DATA_W'(got.ferr));
      if (got.gbe_we || got.lb_we) chk({name, "_dout"}, bus.dout, got.data);
    end
  endtask

  task automatic run_pkt(input pkt_t p);
    logic [DATA_W-1:0] d;
    exp_t              e;
    exp_t              z;
    z = '{gbe_we: 1'b0, lb_we: 1'b0, ferr: 1'b0, data: '0};
    for (int w = 1; w <= p.nwords; w++) begin
      d = {$urandom, $urandom};
      if (w == 1) d[0] = p.dest;
      bus.gbe_afull = p.gbe_af || ((p.raise_at != 0) && (w >= p.raise_at));
      bus.lb_afull  = p.lb_af;
      e.gbe_we = (w <= p.exp_writes) && (p.dest == DEST_GBE);
      e.lb_we  = (w <= p.exp_writes) && (p.dest == DEST_LB);
      e.ferr   = (w == p.ferr_at);
      e.data   = d;
      drive_word(p.name, 1'b1, 1'b1, d, (w == p.nwords), e);
      if (p.gap && (w < p.nwords)) begin
        // Junk with eof set on a held cycle must be ignored.
        drive_word({p.name, "_hold"}, (w % 2) == 1, (w % 2) == 0, {$urandom, $urandom}, 1'b1, z);
      end
    end
    exp_pkt  += p.pkt_inc;
    exp_drop += p.drop_inc;
    chk_ctrs(p.name);
    bus.gbe_afull = 1'b0;
    bus.lb_afull  = 1'b0;
  endtask

  initial begin
    exp_t z;
    exp_t e;
    logic [DATA_W-1:0] d;
    z = '{gbe_we: 1'b0, lb_we: 1'b0, ferr: 1'b0, data: '0};

    //            name               dest nw gaf laf rse gap wr fe pk dr
    pkts.push_back('{"gbe_full",        0, 7, 0, 0, 0, 0, 7, 0, 1, 0});
    pkts.push_back('{"lb_drop",         1, 7, 0, 1, 0, 0, 0, 0, 0, 1});
    pkts.push_back('{"gbe_after_drop",  0, 7, 0, 0, 0, 0, 7, 0, 1, 0});
    pkts.push_back('{"lb_short4",       1, 4, 0, 0, 0, 0, 4, 4, 0, 0});
    pkts.push_back('{"gbe_after_short", 0, 7, 0, 0, 0, 0, 7, 0, 1, 0});
    pkts.push_back('{"gbe_long9",       0, 9, 0, 0, 0, 0, 7, 7, 0, 0});
    pkts.push_back('{"lb_after_long",   1, 7, 0, 0, 0, 0, 7, 0, 1, 0});
    pkts.push_back('{"gbe_gap",         0, 7, 0, 0, 0, 1, 7, 0, 1, 0});
    pkts.push_back('{"gbe_afull_mid",   0, 7, 0, 0, 3, 0, 7, 0, 1, 0});
    pkts.push_back('{"hdr_eof_gbe",     0, 1, 0, 0, 0, 0, 1, 1, 0, 0});
    pkts.push_back('{"hdr_eof_drop",    1, 1, 0, 1, 0, 0, 0, 1, 0, 0});
    pkts.push_back('{"drop_long8",      0, 8, 1, 0, 0, 0, 0, 7, 0, 0});
    pkts.push_back('{"drop_short3",     0, 3, 1, 0, 0, 0, 0, 3, 0, 0});
    pkts.push_back('{"lb_gbe_full_gap", 1, 7, 1, 0, 0, 1, 7, 0, 1, 0});
    pkts.push_back('{"gbe_final",       0, 7, 0, 0, 0, 0, 7, 0, 1, 0});

    rst           = 1'b1;
    ce            = 1'b0;
    bus.din_valid = 1'b0;
    bus.din       = '0;
    bus.din_eof   = 1'b0;
    bus.gbe_afull = 1'b0;
    bus.lb_afull  = 1'b0;
    #12;
    chk("rst_gbe_we", DATA_W'(bus.gbe_we), '0);
    chk("rst_lb_we",  DATA_W'(bus.lb_we),  '0);
    chk("rst_ferr",   DATA_W'(bus.frame_err), '0);
    chk("rst_dout",   bus.dout, '0);
    chk_ctrs("rst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < pkts.size(); i++) run_pkt(pkts[i]);

    // Reset on word 3 of a GbE packet: outputs clear at once, next word is a header.
    for (int w = 1; w <= 2; w++) begin
      d = {$urandom, $urandom};
      if (w == 1) d[0] = DEST_GBE;
      e = '{gbe_we: 1'b1, lb_we: 1'b0, ferr: 1'b0, data: d};
      drive_word("pre_rst", 1'b1, 1'b1, d, 1'b0, e);
    end
    bus.din       = {$urandom, $urandom};
    bus.din_valid = 1'b1;
    ce            = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    exp_pkt  = 0;
    exp_drop = 0;
    chk("mid_rst_gbe_we", DATA_W'(bus.gbe_we), '0);
    chk("mid_rst_lb_we",  DATA_W'(bus.lb_we),  '0);
    chk("mid_rst_ferr",   DATA_W'(bus.frame_err), '0);
    chk("mid_rst_dout",   bus.dout, '0);
    chk_ctrs("mid_rst");
    @(negedge clk);
    rst           = 1'b0;
    bus.din_valid = 1'b0;
    @(posedge clk);
    #1;
    drive_word("post_rst_idle", 1'b0, 1'b1, '0, 1'b0, z);
    run_pkt('{"post_rst_lb", 1, 7, 0, 0, 0, 0, 7, 0, 1, 0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
